// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// Request fields are registered by the master and held until mem_ready.
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data access unit: turns loads/stores into one req/ready bus transaction,
// stalls the pipeline while it is outstanding and formats load data into RDM.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] RDM,
  output logic        StallM,
  output logic        MisalignM,
  mem_access_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdm_q, rdm_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        sz_q, sz_d;
  logic              sgn_q, sgn_d;
  logic              ld_q, ld_d;
  logic              access;

  function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'(4'b0001 << off);
      SZ_HALF: be = 4'(4'b0011 << off);
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{wd[7:0]}};
      SZ_HALF: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sgn);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    b  = w[{off, 3'b000} +: 8];
    h  = off[1] ? w[31:16] : w[15:0];
    sb = b;
    sh = h;
    case (sz)
      SZ_BYTE: r = sgn ? sb : $signed({24'b0, b});
      SZ_HALF: r = sgn ? sh : $signed({16'b0, h});
      default: r = w;
    endcase
    return r;
  endfunction

  assign access    = MemReadM | MemWriteM;
  assign MisalignM = access & ((MemSizeM == 2'b11) ||
                               (MemSizeM == SZ_HALF && ALUOutM[0]) ||
                               (MemSizeM == SZ_WORD && ALUOutM[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdm_d   = rdm_q;
    off_d   = off_q;
    sz_d    = sz_q;
    sgn_d   = sgn_q;
    ld_d    = ld_q;
    StallM  = 1'b0;
    case (state_q)
      IDLE: begin
        // Misaligned/reserved accesses never reach the bus; the trap is raised downstream.
        if (access && !MisalignM) begin
          StallM  = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = ADDR_W'({ALUOutM[31:2], 2'b00});
          be_d    = byte_enables(MemSizeM, ALUOutM[1:0]);
          wdata_d = store_lanes(MemSizeM, WriteDataM);
          off_d   = ALUOutM[1:0];
          sz_d    = MemSizeM;
          sgn_d   = MemSignedM;
          ld_d    = MemReadM & ~MemWriteM;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (ld_q) rdm_d = load_format(bus.mem_rdata, off_q, sz_q, sgn_q);
        end
      end
      // One unstalled cycle lets the instruction move on before the next access is seen.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdm_q   <= 32'h0;
      off_q   <= 2'b00;
      sz_q    <= 2'b00;
      sgn_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdm_q   <= rdm_d;
      off_q   <= off_d;
      sz_q    <= sz_d;
      sgn_q   <= sgn_d;
      ld_q    <= ld_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign RDM           = rdm_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single accesses plus back-to-back and
// mid-access reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  MemSizeM = 2'b00;
  logic        MemSignedM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] RDM;
  logic        StallM;
  logic        MisalignM;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .MemSizeM   (MemSizeM),
    .MemSignedM (MemSignedM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .RDM        (RDM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    int          stalls;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        ewe;
    logic [31:0] erdm;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    MemSizeM   = 2'b00;
    MemSignedM = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
  endtask

  initial begin
    vec_t        v;
    int          stalls;
    int          nbusy;
    logic        saw_req;
    logic        done;
    logic        mis;
    logic [31:0] g_addr;
    logic [31:0] g_wd;
    logic [3:0]  g_be;
    logic        g_we;

    //          rd    wr    sz     sgn   addr          wd            rdata         w  mis   st eaddr         ebe      ewd           ewe   erdm
    vec[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 2, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF};
    vec[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0, 1'b0, 2, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80};
    vec[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0, 1'b0, 2, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 32'h0000_0080};
    vec[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1'b0, 5, 32'h0000_0104, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0080};
    vec[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'h0,         0, 1'b1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0000_0080};
    vec[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 1, 1'b0, 3, 32'h0000_0200, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001};
    vec[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,        32'h8001_F00D, 0, 1'b0, 2, 32'h0000_0200, 4'b0011, 32'h0,        1'b0, 32'h0000_F00D};
    vec[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1'b0, 2, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0000_F00D};
    vec[8]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1122_3344, 32'h5555_5555, 0, 1'b0, 2, 32'h0000_0400, 4'b1111, 32'h1122_3344, 1'b1, 32'h0000_F00D};
    vec[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0000_F00D};
    vec[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0105, 32'h0000_FFFF, 32'h0,         0, 1'b1, 0, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0000_F00D};
    vec[11] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h0000_7F00, 2, 1'b0, 4, 32'h0000_0100, 4'b0010, 32'h0,        1'b0, 32'h0000_007F};

    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_req",   32'(bus.mem_req),   32'h0);
    chk("reset_we",    32'(bus.mem_we),    32'h0);
    chk("reset_be",    32'(bus.mem_be),    32'h0);
    chk("reset_addr",  bus.mem_addr,       32'h0);
    chk("reset_wdata", bus.mem_wdata,      32'h0);
    chk("reset_rdm",   RDM,                32'h0);
    chk("reset_stall", 32'(StallM),        32'h0);

    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      @(negedge clk);
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      MemSizeM   = v.sz;
      MemSignedM = v.sgn;
      ALUOutM    = v.addr;
      WriteDataM = v.wd;
      bus.mem_ready = 1'b0;
      stalls = 0; nbusy = 0; saw_req = 1'b0; done = 1'b0; mis = 1'b0;
      g_addr = 32'h0; g_wd = 32'h0; g_be = 4'h0; g_we = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        #1;
        if (c == 0) mis = MisalignM;
        if (StallM) stalls++;
        if (bus.mem_req) begin
          saw_req = 1'b1;
          g_addr = bus.mem_addr; g_wd = bus.mem_wdata; g_be = bus.mem_be; g_we = bus.mem_we;
          // Disturb the pipeline inputs; the registered request must win.
          ALUOutM    = ~v.addr;
          WriteDataM = ~v.wd;
          MemSignedM = ~v.sgn;
          if (nbusy == v.waits) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = v.rdata;
          end
          nbusy++;
        end else if (c > 0 || !StallM) begin
          done = 1'b1;
        end
        if (!done) @(negedge clk);
      end
      chk($sformatf("v%0d_done", i),    32'(done),    32'h1);
      chk($sformatf("v%0d_misalign", i), 32'(mis),    32'(v.mis));
      chk($sformatf("v%0d_stalls", i),  32'(stalls),  32'(v.stalls));
      chk($sformatf("v%0d_req_seen", i), 32'(saw_req), 32'(!v.mis));
      if (!v.mis) begin
        chk($sformatf("v%0d_addr", i),  g_addr,      v.eaddr);
        chk($sformatf("v%0d_be", i),    32'(g_be),   32'(v.ebe));
        chk($sformatf("v%0d_wdata", i), g_wd,        v.ewd);
        chk($sformatf("v%0d_we", i),    32'(g_we),   32'(v.ewe));
      end
      chk($sformatf("v%0d_rdm", i), RDM, v.erdm);
      bus.mem_ready = 1'b0;
      if (v.mis) begin
        ALUOutM = v.addr;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_noreq", i), 32'(bus.mem_req), 32'h0);
      end
      idle_inputs();
    end

    // Back-to-back load then store with immediate ready.
    @(negedge clk);
    MemReadM = 1'b1; MemSizeM = 2'b10; ALUOutM = 32'h0000_0500;
    bus.mem_rdata = 32'hCAFE_F00D; bus.mem_ready = 1'b0;
    #1 chk("bb_idle_stall", 32'(StallM), 32'h1);
    @(negedge clk); #1;
    chk("bb_req1", 32'(bus.mem_req), 32'h1);
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("bb_done1_stall", 32'(StallM), 32'h0);
    chk("bb_done1_req",   32'(bus.mem_req), 32'h0);
    chk("bb_done1_rdm",   RDM, 32'hCAFE_F00D);
    MemReadM = 1'b0; MemWriteM = 1'b1; ALUOutM = 32'h0000_0504; WriteDataM = 32'h0BAD_C0DE;
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("bb_idle2_req",   32'(bus.mem_req), 32'h0);
    chk("bb_idle2_stall", 32'(StallM), 32'h1);
    @(negedge clk); #1;
    chk("bb_req2",   32'(bus.mem_req), 32'h1);
    chk("bb_we2",    32'(bus.mem_we), 32'h1);
    chk("bb_addr2",  bus.mem_addr, 32'h0000_0504);
    chk("bb_wdata2", bus.mem_wdata, 32'h0BAD_C0DE);
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("bb_done2_req", 32'(bus.mem_req), 32'h0);
    chk("bb_done2_rdm", RDM, 32'hCAFE_F00D);
    idle_inputs();
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("bb_nodup_req",   32'(bus.mem_req), 32'h0);
    chk("bb_nodup_stall", 32'(StallM), 32'h0);

    // Reset pulsed while BUSY, then a late ready.
    @(negedge clk);
    MemReadM = 1'b1; MemSizeM = 2'b10; ALUOutM = 32'h0000_0600;
    bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy_req", 32'(bus.mem_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_req_drop", 32'(bus.mem_req), 32'h0);
    chk("rst_rdm",      RDM, 32'h0);
    chk("rst_be",       32'(bus.mem_be), 32'h0);
    idle_inputs();
    #1 chk("rst_stall", 32'(StallM), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clk); #1;
    chk("late_ready_req",   32'(bus.mem_req), 32'h0);
    chk("late_ready_rdm",   RDM, 32'h0);
    chk("late_ready_stall", 32'(StallM), 32'h0);
    bus.mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
